// File: rtl/crc16_check_ctrl_pkg.sv
// Shared definitions for the CRC-16 command checker: FSM states, CRC constants
// and the single-bit CRC-16 (x^16+x^12+x^5+1) update used by the shift register.
package crc16_check_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;
    localparam int unsigned MIN_LEN     = 16;

    // Feedback enters bit 0 and is folded into the taps feeding bits 5 and 12.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[15];
        return {crc[14:12], crc[11] ^ fb, crc[10:5], crc[4] ^ fb, crc[3:0], fb};
    endfunction

endpackage

// File: rtl/crc16_check_ctrl_lfsr.sv
// CRC-16 shift register with synchronous clear (to the preset) and shift-enable.
module crc16_lfsr
    import crc16_check_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC_PRESET;
        end else if (shift_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc16_check_ctrl.sv
// Serial CRC-16 command checker: counts incoming bits against the commanded length,
// then compares the CRC register with the good-frame residue and latches the verdict.
module crc16_check_ctrl
    import crc16_check_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter logic [15:0] RESIDUE = CRC_RESIDUE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             frame_end,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             err_short,
    output logic [15:0]      crc_out,
    output logic [LEN_W-1:0] bit_cnt
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             short_q, short_d;
    logic             shift_en;
    logic             crc_clear;
    logic             accept;
    logic             last_bit;

    crc16_lfsr u_lfsr (
        .clk     (clk),
        .clear_i (reset | crc_clear),
        .shift_i (shift_en),
        .bit_i   (bit_in),
        .crc_o   (crc_out)
    );

    // The counter never passes len, so an accepted bit can only ever be the final one or an earlier one.
    assign accept   = bit_valid && (cnt_q != len_q);
    assign last_bit = accept && (cnt_q == len_q - 1'b1);

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        ok_d      = ok_q;
        err_d     = err_q;
        short_d   = short_q;
        shift_en  = 1'b0;
        crc_clear = 1'b0;

        if (start) begin
            crc_clear = 1'b1;
            cnt_d     = '0;
            len_d     = len;
            ok_d      = 1'b0;
            err_d     = 1'b0;
            short_d   = 1'b0;
            if (len >= MIN_LEN_L) begin
                state_d = ST_SHIFT;
            end else begin
                state_d = ST_DONE;
                err_d   = 1'b1;
                short_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (accept) begin
                            shift_en = 1'b1;
                            cnt_d    = cnt_q + 1'b1;
                        end
                        if (last_bit) begin
                            state_d = ST_CHECK;
                        end else if (frame_end) begin
                            state_d = ST_DONE;
                            err_d   = 1'b1;
                            short_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        if (crc_out == RESIDUE) ok_d  = 1'b1;
                        else                    err_d = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            short_q <= short_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
    assign done      = (state_q == ST_DONE);
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;
    assign err_short = short_q;
    assign bit_cnt   = cnt_q;

endmodule
